// File: rtl/pipeline_fetch_queue.sv
// Fetch-to-decode instruction queue carrying {PC, instr, PC+4}.
// First-word-fall-through outputs from registered storage; NOP when empty.
module pipeline_fetch_queue #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           instrF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  input  logic                       validF,
  output logic                       readyF,
  input  logic                       stallD,
  input  logic                       flushD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           instrD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic                       validD,
  output logic [$clog2(DEPTH):0]     countQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [WIDTH-1:0] in_mem [DEPTH];
  logic [WIDTH-1:0] p4_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  assign readyF = (count != CW'(DEPTH));
  assign validD = (count != '0);
  assign countQ = count;

  assign push = validF && readyF && !flushD;
  assign pop  = validD && !stallD && !flushD;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; empty outputs are masked instead.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr] <= PCF;
      in_mem[wr_ptr] <= instrF;
      p4_mem[wr_ptr] <= PCPlus4F;
    end
  end

  always_comb begin
    PCD      = '0;
    instrD   = NOP;
    PCPlus4D = '0;
    if (validD) begin
      PCD      = pc_mem[rd_ptr];
      instrD   = in_mem[rd_ptr];
      PCPlus4D = p4_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Bench for pipeline_fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_pipeline_fetch_queue;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  localparam logic [31:0] NOPI = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] PCF = '0;
  logic [W-1:0] instrF = '0;
  logic [W-1:0] PCPlus4F = '0;
  logic         validF = 1'b0;
  logic         readyF;
  logic         stallD = 1'b0;
  logic         flushD = 1'b0;
  logic [W-1:0] PCD;
  logic [W-1:0] instrD;
  logic [W-1:0] PCPlus4D;
  logic         validD;
  logic [2:0]   countQ;

  pipeline_fetch_queue #(.WIDTH(W), .DEPTH(D), .NOP(NOPI)) dut (
    .clk      (clk),
    .rst      (rst),
    .PCF      (PCF),
    .instrF   (instrF),
    .PCPlus4F (PCPlus4F),
    .validF   (validF),
    .readyF   (readyF),
    .stallD   (stallD),
    .flushD   (flushD),
    .PCD      (PCD),
    .instrD   (instrD),
    .PCPlus4D (PCPlus4D),
    .validD   (validD),
    .countQ   (countQ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
  } ent_t;

  ent_t q[$];
  bit   known = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_model();
    int n;
    n = q.size();
    check("validD", 32'(validD), 32'(n != 0));
    check("readyF", 32'(readyF), 32'(n != D));
    check("countQ", 32'(countQ), 32'(n));
    check("instrD", instrD, (n != 0) ? q[0].ins : NOPI);
    check("PCD", PCD, (n != 0) ? q[0].pc : 32'h0);
    check("PCPlus4D", PCPlus4D, (n != 0) ? q[0].p4 : 32'h0);
  endtask

  // Drive one cycle at the falling edge, compare outputs, advance the model.
  task automatic cyc(input bit r, input bit v, input logic [31:0] pc,
                     input logic [31:0] ins, input bit s, input bit f);
    bit do_push;
    bit do_pop;
    ent_t e;
    @(negedge clk);
    rst = r;
    validF = v;
    PCF = pc;
    instrF = ins;
    PCPlus4F = pc + 32'd4;
    stallD = s;
    flushD = f;
    if (known) cmp_model();
    if (r || f) begin
      q.delete();
      if (r) known = 1'b1;
    end else begin
      do_push = v && (q.size() < D);
      do_pop = (q.size() > 0) && !s;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = pc;
        e.ins = ins;
        e.p4 = pc + 32'd4;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    // Reset held two cycles with fetch active
    cyc(1, 1, 32'h40, 32'h99, 0, 0);
    cyc(1, 1, 32'h44, 32'h98, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_validD", 32'(validD), 32'd0);
    check("rst_readyF", 32'(readyF), 32'd1);
    check("rst_instrD", instrD, 32'h13);
    check("rst_PCD", PCD, 32'h0);
    check("rst_countQ", 32'(countQ), 32'd0);

    // Streaming
    cyc(0, 1, 32'h0, 32'hA0, 0, 0);
    cyc(0, 1, 32'h4, 32'hA1, 0, 0);
    check("str0", instrD, 32'hA0);
    check("str0_p4", PCPlus4D, 32'h4);
    cyc(0, 1, 32'h8, 32'hA2, 0, 0);
    check("str1", instrD, 32'hA1);
    check("str_cnt", 32'(countQ), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("str2", instrD, 32'hA2);
    check("str2_p4", PCPlus4D, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    check("str_empty", 32'(validD), 32'd0);

    // Fill while stalled; the 5th push is refused
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("fill_cnt", 32'(countQ), 32'd4);
    check("fill_rdy", 32'(readyF), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("drain_pc", PCD, 32'h100 + 32'(4 * i));
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("drain_empty", 32'(validD), 32'd0);

    // Flush with a simultaneous push and stall
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 32'h180 + 32'(4 * i), 32'hC0 + 32'(i), 1, 0);
    cyc(0, 1, 32'h200, 32'hDEAD, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check("flush_valid", 32'(validD), 32'd0);
    check("flush_cnt", 32'(countQ), 32'd0);
    check("flush_instr", instrD, 32'h13);

    // Pop at full does not admit a same-cycle push
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 32'h300 + 32'(4 * i), 32'hD0 + 32'(i), 1, 0);
    cyc(0, 1, 32'h340, 32'hDF, 0, 0);
    cyc(0, 1, 32'h344, 32'hDE, 1, 0);
    check("fb_cnt", 32'(countQ), 32'd3);
    check("fb_rdy", 32'(readyF), 32'd1);
    check("fb_head", PCD, 32'h304);
    cyc(0, 0, 0, 0, 1, 0);
    check("fb_refill", 32'(countQ), 32'd4);

    // Random traffic, including wrap, flushes and mid-run resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 70),
          {$urandom_range(0, 32'h3FFF), 2'b00},
          $urandom,
          ($urandom_range(0, 99) < 35),
          ($urandom_range(0, 99) < 4));
    end
    cyc(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_queue.md
Name: pipeline_fetch_queue

Overview:
Parametrised fetch-to-decode instruction buffer. It replaces the single-entry, always-loading fetch/decode register with a DEPTH-entry FIFO that carries {PC, instr, PC+4}. It adds valid/ready handshaking, decode stall and flush with NOP bubble injection. It sits between the fetch stage (PC register plus instruction memory) and the decode stage, and lets fetch run ahead while decode is stalled.

Parameters:
WIDTH, 32, width of PC, instruction and PC+4 fields
DEPTH, 4, number of queue entries; power of two, minimum 2
NOP, 32'h00000013, instruction presented on instrD when the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
PCF  input  WIDTH  PC of the fetched instruction
instrF  input  WIDTH  fetched instruction
PCPlus4F  input  WIDTH  PC+4 of the fetched instruction
validF  input  1  fetch presents a valid entry this cycle
readyF  output  1  queue can accept an entry; equals (count != DEPTH)
stallD  input  1  decode cannot consume this cycle
flushD  input  1  discard all queued and incoming entries (branch/jump redirect)
PCD  output  WIDTH  head-entry PC
instrD  output  WIDTH  head-entry instruction, or NOP when empty
PCPlus4D  output  WIDTH  head-entry PC+4
validD  output  1  head entry is valid; equals (count != 0)
countQ  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage array [DEPTH] x 3 fields; wr_ptr and rd_ptr, each $clog2(DEPTH) bits; count, $clog2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH by natural overflow. Wrap-around must be seamless.
- push = validF && readyF && !flushD.
- pop = validD && !stallD && !flushD.
- On push: write the entry at wr_ptr, then wr_ptr+1.
- On pop: rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output timing is first-word-fall-through from registered storage.
  - PCD, instrD and PCPlus4D are combinational reads of the entry at rd_ptr.
  - There is no same-cycle bypass: an entry pushed at edge N appears on the outputs after edge N, so push-to-validD latency is 1 cycle.
- When empty (count==0): instrD=NOP, PCD=0, PCPlus4D=0, validD=0. Outputs are masked regardless of stale storage contents.
- Full (count==DEPTH): readyF=0. validF is ignored and the fetch stage must hold its PC.
  - A pop while full does not enable a same-cycle push. readyF rises the cycle after the pop.
- Empty with push and stallD=0: no pop that cycle. The entry is consumable from the next cycle.
- flushD=1 (synchronous):
  - Next cycle: count=0, rd_ptr=wr_ptr=0.
  - Any simultaneous push is discarded; any simultaneous pop is suppressed.
  - flushD takes priority over stallD.
  - During the flush cycle the outputs still show the current head, and validD reflects the current count. Decode must ignore a flushed stage.
- Reset:
  - rst has priority over flushD and all other inputs. Next cycle: count=0, pointers=0, validD=0, readyF=1, instrD=NOP, PCD=0, PCPlus4D=0, countQ=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation (queue partially full, push/pop in flight) drops everything with no partial update.
- Stall: stallD=1 with validD=1 holds the head and its outputs stable. Pushes continue until full.
- Throughput: with stallD=0 and validF=1 continuously, there is one push and one pop per cycle in steady state. count stays at 1 after the first cycle.

Test Plan:
- Reset → validD=0, readyF=1, instrD=32'h00000013, PCD=0, countQ=0. Hold rst for 2 cycles with validF=1 → still empty afterwards.
- Streaming: push PC=0x0,0x4,0x8 with instr 0xA0,0xA1,0xA2 and stallD=0 → instrD shows 0xA0,0xA1,0xA2 on consecutive cycles starting 1 cycle after the first push. PCPlus4D = PC+4 on each.
- Fill and stall: stallD=1, push 5 entries (PC 0x100..0x110), DEPTH=4 → readyF=0 after the 4th push, the 5th is not accepted, countQ=4. Release stall → 0x100,0x104,0x108,0x10C drain in order, then validD=0.
- Wrap-around: cycle 10 push/pop pairs with DEPTH=4 and random stalls. Compare against a reference model → order preserved across pointer wrap, no duplicate or lost entries.
- Flush: with 3 entries queued, assert flushD together with validF=1 (PC=0x200) and stallD=1 → next cycle validD=0, countQ=0, instrD=NOP, and 0x200 is never output.
- Full-boundary pop: at count=4 pop once with validF=1 → count=3, no push that cycle, readyF=1 next cycle. Push then succeeds and count returns to 4.
